// File: rtl/pmod_cls_pkg.sv
// Shared types and constants for the PMOD CLS text update sequencer.
package pmod_cls_pkg;

    typedef enum logic [2:0] {
        ST_PACE     = 3'd0,
        ST_SNAP     = 3'd1,
        ST_CLR_REQ  = 3'd2,
        ST_CLR_WAIT = 3'd3,
        ST_L1_REQ   = 3'd4,
        ST_L1_WAIT  = 3'd5,
        ST_L2_REQ   = 3'd6,
        ST_L2_WAIT  = 3'd7
    } t_cls_seq_state;

    typedef enum logic [1:0] {
        SEL_CLR = 2'd0,
        SEL_L1  = 2'd1,
        SEL_L2  = 2'd2
    } t_cls_cmd_sel;

    localparam int c_cls_line_bytes = 16;
    localparam int c_cls_line_bits  = c_cls_line_bytes * 8;
    localparam logic [7:0] c_ascii_space = 8'h20;

    // Refresh period in ce ticks; fast simulation shrinks it by 1000.
    function automatic int refresh_ticks(input int fast, input int fclk, input int ms);
        int t;
        t = fclk / 1000 * ms;
        if (fast != 0) t = t / 1000;
        return t;
    endfunction

endpackage

// File: rtl/cls_cmd_handshake.sv
// Drives one selected driver command level until the driver acknowledges by dropping
// ready on a ce tick, or until the ack timer expires.
module cls_cmd_handshake
    import pmod_cls_pkg::*;
#(
    parameter int parm_ack_timeout = 1023
) (
    input  logic       i_ext_spi_clk_x,
    input  logic       i_arst_n,
    input  logic       i_spi_ce_4x,
    input  logic       req_en,
    input  logic [1:0] sel,
    input  logic       i_command_ready,
    output logic [2:0] cmd,
    output logic       ack,
    output logic       tmo
);

    localparam int c_aw = (parm_ack_timeout < 2) ? 1 : $clog2(parm_ack_timeout + 1);

    logic [c_aw-1:0] ack_cnt;
    logic [2:0]      sel_onehot;
    logic            cmd_on;

    assign cmd_on = |cmd;

    always_comb begin
        sel_onehot = 3'b000;
        case (t_cls_cmd_sel'(sel))
            SEL_CLR: sel_onehot = 3'b001;
            SEL_L1:  sel_onehot = 3'b010;
            SEL_L2:  sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    end

    // Ack has priority: a ready drop on the final timer tick still counts as accepted.
    assign ack = i_spi_ce_4x & cmd_on & ~i_command_ready;
    assign tmo = i_spi_ce_4x & cmd_on & i_command_ready
                 & (ack_cnt == c_aw'(parm_ack_timeout - 1));

    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cmd     <= 3'b000;
            ack_cnt <= '0;
        end else if (i_spi_ce_4x) begin
            if (cmd_on) begin
                if (ack || tmo) cmd <= 3'b000;
                else            ack_cnt <= ack_cnt + 1'b1;
            end else if (req_en && i_command_ready) begin
                cmd     <= sel_onehot;
                ack_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pmod_cls_text_update_seq.sv
// Snapshots two text lines and pushes clear/line1/line2 commands to the PMOD CLS driver,
// rewriting only changed lines, paced by a minimum refresh interval.
module pmod_cls_text_update_seq
    import pmod_cls_pkg::*;
#(
    parameter int parm_fast_simulation = 0,
    parameter int FCLK_ce              = 2500000,
    parameter int parm_refresh_ms      = 100,
    parameter int parm_ack_timeout     = 1023
) (
    input  logic         i_ext_spi_clk_x,
    input  logic         i_arst_n,
    input  logic         i_spi_ce_4x,
    input  logic         i_update_req,
    input  logic         i_force_clear,
    input  logic [127:0] i_text_line1,
    input  logic [127:0] i_text_line2,
    input  logic         i_command_ready,
    output logic         o_cmd_wr_clear_display,
    output logic         o_cmd_wr_text_line1,
    output logic         o_cmd_wr_text_line2,
    output logic [127:0] o_dat_ascii_line1,
    output logic [127:0] o_dat_ascii_line2,
    output logic         o_busy,
    output logic         o_timeout_err,
    output logic [2:0]   o_dbg_state
);

    localparam int c_refresh_t = refresh_ticks(parm_fast_simulation, FCLK_ce, parm_refresh_ms);
    localparam int c_rw        = (c_refresh_t < 2) ? 1 : $clog2(c_refresh_t + 1);

    t_cls_seq_state state, state_nx;
    logic [c_rw-1:0] refresh_cnt;
    logic [127:0]    shadow1, shadow2;
    logic            update_pend, force_pend, dirty1, dirty2;
    logic            snap_dirty1, snap_dirty2, req_en, hs_ack, hs_tmo;
    logic [1:0]      sel;
    logic [2:0]      cmd;

    assign snap_dirty1 = (i_text_line1 != shadow1) | force_pend;
    assign snap_dirty2 = (i_text_line2 != shadow2) | force_pend;

    always_comb begin
        req_en = 1'b0;
        sel    = SEL_CLR;
        case (state)
            ST_CLR_REQ: begin req_en = 1'b1; sel = SEL_CLR; end
            ST_L1_REQ:  begin req_en = 1'b1; sel = SEL_L1;  end
            ST_L2_REQ:  begin req_en = 1'b1; sel = SEL_L2;  end
            default:    begin req_en = 1'b0; sel = SEL_CLR; end
        endcase
    end

    cls_cmd_handshake #(.parm_ack_timeout(parm_ack_timeout)) u_hs (
        .i_ext_spi_clk_x (i_ext_spi_clk_x),
        .i_arst_n        (i_arst_n),
        .i_spi_ce_4x     (i_spi_ce_4x),
        .req_en          (req_en),
        .sel             (sel),
        .i_command_ready (i_command_ready),
        .cmd             (cmd),
        .ack             (hs_ack),
        .tmo             (hs_tmo)
    );

    always_comb begin
        state_nx = state;
        if (i_spi_ce_4x) begin
            case (state)
                ST_PACE:
                    if ((refresh_cnt == c_rw'(c_refresh_t)) && (update_pend || force_pend))
                        state_nx = ST_SNAP;
                ST_SNAP:
                    if (force_pend)       state_nx = ST_CLR_REQ;
                    else if (snap_dirty1) state_nx = ST_L1_REQ;
                    else if (snap_dirty2) state_nx = ST_L2_REQ;
                    else                  state_nx = ST_PACE;
                ST_CLR_REQ:
                    if (hs_tmo)      state_nx = ST_PACE;
                    else if (hs_ack) state_nx = ST_CLR_WAIT;
                ST_L1_REQ:
                    if (hs_tmo)      state_nx = ST_PACE;
                    else if (hs_ack) state_nx = ST_L1_WAIT;
                ST_L2_REQ:
                    if (hs_tmo)      state_nx = ST_PACE;
                    else if (hs_ack) state_nx = ST_L2_WAIT;
                // A clear blanks both lines, so line 1 always follows it.
                ST_CLR_WAIT:
                    if (i_command_ready) state_nx = ST_L1_REQ;
                ST_L1_WAIT:
                    if (i_command_ready) state_nx = dirty2 ? ST_L2_REQ : ST_PACE;
                ST_L2_WAIT:
                    if (i_command_ready) state_nx = ST_PACE;
                default: state_nx = ST_PACE;
            endcase
        end
    end

    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) state <= ST_PACE;
        else           state <= state_nx;
    end

    // Requests are latched on every clock edge; a set in the SNAP tick outlives its clear.
    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            update_pend <= 1'b0;
            force_pend  <= 1'b1;
        end else begin
            if (i_update_req)                                 update_pend <= 1'b1;
            else if (i_spi_ce_4x && state == ST_SNAP)         update_pend <= 1'b0;
            if (i_force_clear || hs_tmo)                      force_pend  <= 1'b1;
            else if (i_spi_ce_4x && state == ST_CLR_WAIT && i_command_ready)
                                                              force_pend  <= 1'b0;
        end
    end

    always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
        if (!i_arst_n) begin
            refresh_cnt       <= '0;
            o_dat_ascii_line1 <= '0;
            o_dat_ascii_line2 <= '0;
            shadow1           <= '0;
            shadow2           <= '0;
            dirty1            <= 1'b0;
            dirty2            <= 1'b0;
            o_timeout_err     <= 1'b0;
        end else if (i_spi_ce_4x) begin
            if (state_nx == ST_PACE && state != ST_PACE)
                refresh_cnt <= '0;
            else if (state == ST_PACE && refresh_cnt != c_rw'(c_refresh_t))
                refresh_cnt <= refresh_cnt + 1'b1;
            if (state == ST_SNAP) begin
                o_dat_ascii_line1 <= i_text_line1;
                o_dat_ascii_line2 <= i_text_line2;
                dirty1            <= snap_dirty1;
                dirty2            <= snap_dirty2;
            end
            if (state == ST_L1_WAIT && i_command_ready) shadow1 <= o_dat_ascii_line1;
            if (state == ST_L2_WAIT && i_command_ready) shadow2 <= o_dat_ascii_line2;
            if (hs_tmo) o_timeout_err <= 1'b1;
        end
    end

    assign o_cmd_wr_clear_display = cmd[0];
    assign o_cmd_wr_text_line1    = cmd[1];
    assign o_cmd_wr_text_line2    = cmd[2];
    assign o_busy                 = (state != ST_PACE);
    assign o_dbg_state            = state;

endmodule

// File: tb/tb_pmod_cls_text_update_seq.sv
// Directed bench for the PMOD CLS text update sequencer with a hand-driven driver model.
module tb_pmod_cls_text_update_seq;
    import pmod_cls_pkg::*;

    logic         clk, rst_n, ce, update_req, force_clear, command_ready;
    logic [127:0] text1, text2;
    logic         cmd_clr, cmd_l1, cmd_l2, busy, tmo_err;
    logic [127:0] dat1, dat2;
    logic [2:0]   dbg_state;
    logic [2:0]   cmd_vec;
    int           n_checks, n_errors;
    int unsigned  ce_div;

    assign cmd_vec = {cmd_l2, cmd_l1, cmd_clr};

    pmod_cls_text_update_seq #(
        .parm_fast_simulation (1),
        .FCLK_ce              (2500000),
        .parm_refresh_ms      (100),
        .parm_ack_timeout     (1023)
    ) dut (
        .i_ext_spi_clk_x        (clk),
        .i_arst_n               (rst_n),
        .i_spi_ce_4x            (ce),
        .i_update_req           (update_req),
        .i_force_clear          (force_clear),
        .i_text_line1           (text1),
        .i_text_line2           (text2),
        .i_command_ready        (command_ready),
        .o_cmd_wr_clear_display (cmd_clr),
        .o_cmd_wr_text_line1    (cmd_l1),
        .o_cmd_wr_text_line2    (cmd_l2),
        .o_dat_ascii_line1      (dat1),
        .o_dat_ascii_line2      (dat2),
        .o_busy                 (busy),
        .o_timeout_err          (tmo_err),
        .o_dbg_state            (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ce is high on every second clock, changed on the falling edge.
    initial begin
        ce     = 1'b0;
        ce_div = 0;
        forever begin
            @(negedge clk);
            ce_div = ce_div + 1;
            ce     = ce_div[0];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (!ce) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input string tag);
        int n;
        n = 0;
        while (dbg_state !== st && n < 2000) begin
            wait_tick();
            n++;
        end
        chk(tag, 128'(dbg_state), 128'(st));
    endtask

    task automatic wait_cmd(input string tag);
        int n;
        n = 0;
        while (cmd_vec === 3'b000 && n < 2000) begin
            wait_tick();
            n++;
        end
        chk({tag, " cmd_seen"}, 128'(cmd_vec != 3'b000), 128'(1));
    endtask

    // Driver model: see the command, keep ready high for 'hold' ticks, then acknowledge.
    task automatic serve(input int idx, input int hold, input string tag);
        logic [2:0] exp_vec;
        exp_vec = 3'b001 << idx;
        wait_cmd(tag);
        chk({tag, " onehot"}, 128'(cmd_vec), 128'(exp_vec));
        chk({tag, " busy"}, 128'(busy), 128'(1));
        for (int i = 0; i < hold; i++) begin
            wait_tick();
            chk({tag, " held"}, 128'(cmd_vec), 128'(exp_vec));
        end
        command_ready = 1'b0;
        wait_tick();
        chk({tag, " dropped"}, 128'(cmd_vec), 128'(0));
        chk({tag, " wait_state"}, 128'(dbg_state), 128'(3 + 2 * idx));
        wait_tick();
        chk({tag, " busy_in_wait"}, 128'(busy), 128'(1));
        command_ready = 1'b1;
        wait_tick();
    endtask

    task automatic pulse_update();
        @(negedge clk) update_req = 1'b1;
        @(negedge clk) update_req = 1'b0;
    endtask

    initial begin
        int n;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        update_req    = 1'b0;
        force_clear   = 1'b0;
        command_ready = 1'b1;
        text1         = "HELLO WORLD     ";
        text2         = "LINE TWO       A";

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst cmd", 128'(cmd_vec), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst err", 128'(tmo_err), 128'(0));
        chk("rst dat1", dat1, 128'(0));
        chk("rst dat2", dat2, 128'(0));
        chk("rst state", 128'(dbg_state), 128'(ST_PACE));
        @(negedge clk) rst_n = 1'b1;

        // 1: first pass after reset is clear, line1, line2
        serve(0, 1, "t1 clr");
        serve(1, 2, "t1 l1");
        serve(2, 1, "t1 l2");
        chk("t1 end state", 128'(dbg_state), 128'(ST_PACE));
        chk("t1 busy low", 128'(busy), 128'(0));
        chk("t1 dat1", dat1, "HELLO WORLD     ");
        chk("t1 dat2", dat2, "LINE TWO       A");
        chk("t1 dat1 last char", 128'(dat1[7:0]), 128'(c_ascii_space));

        // 2: unchanged text -> SNAP then straight back to PACE
        pulse_update();
        wait_state(ST_SNAP, "t2 snap");
        chk("t2 cmd in snap", 128'(cmd_vec), 128'(0));
        wait_tick();
        chk("t2 back to pace", 128'(dbg_state), 128'(ST_PACE));
        chk("t2 cmd after", 128'(cmd_vec), 128'(0));
        chk("t2 busy", 128'(busy), 128'(0));

        // 3: only line2 byte 0 changes
        text2 = "LINE TWO       B";
        pulse_update();
        serve(2, 1, "t3 l2");
        chk("t3 byte0", 128'(dat2[7:0]), 128'(8'h42));
        chk("t3 end state", 128'(dbg_state), 128'(ST_PACE));

        // 4: ready low while in L1_REQ holds the command off
        text1 = "HELLO THERE     ";
        command_ready = 1'b0;
        pulse_update();
        wait_state(ST_L1_REQ, "t4 l1_req");
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            chk("t4 cmd held off", 128'(cmd_vec), 128'(0));
        end
        command_ready = 1'b1;
        serve(1, 2, "t4 l1");
        chk("t4 end state", 128'(dbg_state), 128'(ST_PACE));
        chk("t4 dat1", dat1, "HELLO THERE     ");

        // 5: driver never acknowledges -> timeout after 1023 ticks
        text2 = "TIMEOUT LINE   C";
        pulse_update();
        wait_cmd("t5");
        chk("t5 is l2", 128'(cmd_vec), 128'(3'b100));
        n = 0;
        while (cmd_vec !== 3'b000 && n < 1100) begin
            wait_tick();
            n++;
            if (n == 1000) chk("t5 err not early", 128'(tmo_err), 128'(0));
        end
        chk("t5 ticks to timeout", 128'(n), 128'(1023));
        chk("t5 err", 128'(tmo_err), 128'(1));
        chk("t5 state", 128'(dbg_state), 128'(ST_PACE));
        serve(0, 1, "t5 clr");
        serve(1, 1, "t5 l1");
        serve(2, 1, "t5 l2");
        chk("t5 err sticky", 128'(tmo_err), 128'(1));

        // 6: async reset while line2 command is up
        text2 = "RESET CASE     D";
        pulse_update();
        wait_cmd("t6");
        chk("t6 is l2", 128'(cmd_vec), 128'(3'b100));
        #2 rst_n = 1'b0;
        #1;
        chk("t6 cmd async", 128'(cmd_vec), 128'(0));
        chk("t6 busy async", 128'(busy), 128'(0));
        chk("t6 err cleared", 128'(tmo_err), 128'(0));
        chk("t6 dat2 cleared", dat2, 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        serve(0, 1, "t6 clr");
        serve(1, 1, "t6 l1");
        serve(2, 1, "t6 l2");
        chk("t6 dat2", dat2, "RESET CASE     D");

        // 7: force_clear on unchanged text rewrites everything
        @(negedge clk) force_clear = 1'b1;
        @(negedge clk) force_clear = 1'b0;
        serve(0, 1, "t7 clr");
        serve(1, 1, "t7 l1");
        serve(2, 1, "t7 l2");
        chk("t7 end state", 128'(dbg_state), 128'(ST_PACE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
